fm_add_par_bram_wr: RTL

- Downstream stage of the feature-map-add serial-to-parallel packer. Consumes its wide `par`/`par_valid` beats and writes each beat as one BRAM word at incrementing addresses from a programmable base.
- The packer has no backpressure, so this block absorbs BRAM stalls in a small FIFO. It flags and counts beats lost to overflow.
- Emits `frame_done` after FRAME_BEATS words are written.

---
 rtl/fm_add_par_bram_wr.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fm_add_par_bram_wr.sv
// -----------------------------------------------------------------------------
// fm_add_par_bram_wr
//
// Downstream stage of the feature-map-add serial-to-parallel packer. Each wide
// par/par_valid beat is written as one BRAM word at base_addr + n, where n is
// the index of the write within the frame. The address wraps modulo
// 2^BRAM_ADDR_WIDTH.
//
// The packer cannot be stalled, so a small FIFO absorbs cycles in which the
// BRAM port is not granted. A beat that arrives while the FIFO is full, and
// with no pop in the same cycle, is lost. A lost beat sets the sticky drop flag.
// frame_done pulses together with the FRAME_BEATS-th write strobe.
//
// Optional build macro: FM_ADD_PAR_WR_DROP_CNT_EN
//   Adds output drop_cnt[15:0], a saturating count of lost beats. It is
//   cleared by reset and by an accepted start.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        one-cycle pulse; arms a frame when in IDLE
//   base_addr    first write address, sampled on an accepted start
//   par          parallel beat (APP_DATA_WIDTH*SEQ_CNT bits)
//   par_valid    beat strobe
//   bram_ready   BRAM grant; high = a write may be issued next cycle
//   bram_en/we   BRAM enable / write enable
//   bram_addr    write address
//   bram_din     write data
//   busy         high while the frame is running
//   frame_done   one-cycle pulse with the final write strobe
//   fifo_full    registered: FIFO occupancy == FIFO_DEPTH
//   drop         sticky: a beat was lost during this frame
// -----------------------------------------------------------------------------
module fm_add_par_bram_wr #(
  parameter int SEQ_CNT         = 5,
  parameter int APP_DATA_WIDTH  = 64,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int FRAME_BEATS     = 1024,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [BRAM_ADDR_WIDTH-1:0]          base_addr,
  input  logic [APP_DATA_WIDTH*SEQ_CNT-1:0]   par,
  input  logic                                par_valid,
  input  logic                                bram_ready,
  output logic                                bram_en,
  output logic                                bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]          bram_addr,
  output logic [APP_DATA_WIDTH*SEQ_CNT-1:0]   bram_din,
  output logic                                busy,
  output logic                                frame_done,
  output logic                                fifo_full,
  output logic                                drop
`ifdef FM_ADD_PAR_WR_DROP_CNT_EN
  ,
  output logic [15:0]                         drop_cnt
`endif
);

  localparam int PAR_W  = APP_DATA_WIDTH * SEQ_CNT;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(FRAME_BEATS + 1);

  localparam logic [OCC_W-1:0]  DEPTH_C = OCC_W'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0] BEATS_C = BEAT_W'(FRAME_BEATS);
  localparam logic [BEAT_W-1:0] LAST_C  = BEAT_W'(FRAME_BEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [PAR_W-1:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic [BEAT_W-1:0]          push_cnt_q, wr_cnt_q;
  logic [BRAM_ADDR_WIDTH-1:0] base_q;

  logic arm, push_req, push, pop, lost, last_pop;

  // Datapath decisions for this cycle.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    arm      = (state_q == IDLE) && start;
    push_req = (state_q == RUN) && par_valid && (push_cnt_q < BEATS_C);
    // The pop looks only at the registered occupancy. A beat pushed into an
    // empty FIFO is therefore stored first and popped one cycle later.
    pop      = (state_q == RUN) && (occ_q != '0) && bram_ready;
    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    push     = push_req && ((occ_q != DEPTH_C) || pop);
    lost     = push_req && !push;
    last_pop = pop && (wr_cnt_q == LAST_C);

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_pop) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      push_cnt_q <= '0;
      wr_cnt_q   <= '0;
      base_q     <= '0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      fifo_full  <= 1'b0;
      drop       <= 1'b0;
    end else begin
      state_q <= state_d;
      bram_en <= pop;
      bram_we <= pop;
      if (arm) begin
        base_q     <= base_addr;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        occ_q      <= '0;
        push_cnt_q <= '0;
        wr_cnt_q   <= '0;
        fifo_full  <= 1'b0;
        drop       <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q   <= wr_ptr_q + 1'b1;
          push_cnt_q <= push_cnt_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q  <= rd_ptr_q + 1'b1;
          wr_cnt_q  <= wr_cnt_q + 1'b1;
          // The address wraps naturally at the BRAM address width.
          bram_addr <= base_q + BRAM_ADDR_WIDTH'(wr_cnt_q);
          bram_din  <= mem[rd_ptr_q];
        end
        occ_q     <= occ_d;
        fifo_full <= (occ_d == DEPTH_C);
        if (lost) drop <= 1'b1;
      end
    end
  end

  // NOTE: FIFO storage has no reset. Occupancy and the pointers decide which
  // entries are valid, and leaving the array unreset lets it map onto plain
  // RAM/SRL cells.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= par;
  end

`ifdef FM_ADD_PAR_WR_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (arm) begin
      drop_cnt <= '0;
    end else if (lost && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
